// File: rtl/wb_serializer_pkg.sv
// Purpose: shared constants and types for the Wishbone-attached word serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: register byte addresses, CTRL/STATUS bit positions, divider
// width and the serializer state encoding.
package wb_serializer_pkg;

  // Word-aligned register byte addresses.
  localparam int ADDR_CTRL   = 'h0;
  localparam int ADDR_DATA   = 'h4;
  localparam int ADDR_DIV    = 'h8;
  localparam int ADDR_STATUS = 'hC;

  // CTRL bit positions.
  localparam int START_BIT = 0;

  // STATUS bit positions.
  localparam int BUSY_BIT = 0;
  localparam int DONE_BIT = 1;

  // Only the low half of DIV is implemented; the upper bits read as zero.
  localparam int DIV_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/serializer_piso.sv
// Purpose: parallel-in serial-out shifter, MSB first, each bit held i_div+1 cycles.
// Latency: first bit on o_data the cycle after i_load; frame lasts DW*(i_div+1) cycles.
// Backpressure: none; i_load is honoured only in IDLE and ignored while busy.
//
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_load             start a frame (only honoured in IDLE)
//   i_word, i_div      word to send, extra cycles per bit (sampled on load, i_div also on reload)
//   o_data             serial line, 0 when idle
//   o_busy             frame in progress
//   o_done_pulse       high during the final cycle of a frame (the edge ending it)
module serializer_piso
  import wb_serializer_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [DW-1:0]    i_word,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_data,
  output logic             o_busy,
  output logic             o_done_pulse
);

  localparam int CW = $clog2(DW);

  ser_state_t       r_state;
  logic [DW-1:0]    r_shreg;
  logic [CW-1:0]    r_bitcnt;
  logic [DIV_W-1:0] r_divcnt;

  ser_state_t       w_state_nxt;
  logic [DW-1:0]    w_shreg_nxt;
  logic [CW-1:0]    w_bitcnt_nxt;
  logic [DIV_W-1:0] w_divcnt_nxt;
  logic             w_last;

  // Final cycle of the frame: last bit has been held for its full period.
  assign w_last = (r_state == SHIFT) && (r_divcnt == '0) && (r_bitcnt == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_divcnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_divcnt <= w_divcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_divcnt_nxt = r_divcnt;
    case (r_state)
      IDLE: begin
        if (i_load) begin
          w_shreg_nxt  = i_word;
          w_bitcnt_nxt = CW'(DW - 1);
          w_divcnt_nxt = i_div;
          w_state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (r_divcnt != '0) begin
          w_divcnt_nxt = r_divcnt - DIV_W'(1);
        end else if (r_bitcnt != '0) begin
          w_shreg_nxt  = {r_shreg[DW-2:0], 1'b0};
          w_bitcnt_nxt = r_bitcnt - CW'(1);
          // i_div cannot change mid-frame (writes are refused while busy),
          // so reloading from the live register is equivalent to a snapshot.
          w_divcnt_nxt = i_div;
        end else begin
          w_shreg_nxt = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_busy       = (r_state == SHIFT);
  assign o_data       = (r_state == SHIFT) && r_shreg[DW-1];
  assign o_done_pulse = w_last;

endmodule

// File: rtl/wb_serializer_unit.sv
// Purpose: Wishbone B4 classic slave exposing CTRL/DATA/DIV/STATUS around a serializer.
// Latency: every accepted request terminates (ACK_O or ERR_O) exactly one cycle later.
// Backpressure: one wait state per access; new requests are ignored while a termination is high.
//
// Ports:
//   CLK_I, RST_I       shared clock, synchronous active-low reset
//   CYC_I, STB_I, WE_I Wishbone request qualifiers
//   ADR_I, DAT_I       byte address, write data
//   DAT_O              read data, zero except while ACK_O of a read
//   ACK_O, ERR_O       normal / error termination, one cycle each
//   data_o             serial output
module wb_serializer_unit
  import wb_serializer_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          CYC_I,
  input  logic          STB_I,
  input  logic          WE_I,
  input  logic [AW-1:0] ADR_I,
  input  logic [DW-1:0] DAT_I,
  output logic [DW-1:0] DAT_O,
  output logic          ACK_O,
  output logic          ERR_O,
  output logic          data_o
);

  logic [DW-1:0]    r_data;
  logic [DIV_W-1:0] r_div;
  logic             r_done;
  logic             r_ack;
  logic             r_err;
  logic [DW-1:0]    r_dat;

  logic          w_req;
  logic          w_sel_ctrl;
  logic          w_sel_data;
  logic          w_sel_div;
  logic          w_sel_status;
  logic          w_misalign;
  logic          w_unmapped;
  logic          w_err;
  logic          w_wr;
  logic          w_start;
  logic          w_busy;
  logic          w_done_pulse;
  logic [DW-1:0] w_rdata;

  // A new request is only taken once the previous termination has dropped,
  // which gives the fixed one-wait-state, two-cycle access rhythm.
  assign w_req = CYC_I & STB_I & ~r_ack & ~r_err;

  assign w_misalign   = (ADR_I[1:0] != 2'b00);
  assign w_sel_ctrl   = (ADR_I == AW'(ADDR_CTRL));
  assign w_sel_data   = (ADR_I == AW'(ADDR_DATA));
  assign w_sel_div    = (ADR_I == AW'(ADDR_DIV));
  assign w_sel_status = (ADR_I == AW'(ADDR_STATUS));
  assign w_unmapped   = ~(w_sel_ctrl | w_sel_data | w_sel_div | w_sel_status);

  // Refused accesses have no side effect at all: a START or DIV change
  // while busy would corrupt the running frame.
  assign w_err = w_misalign
               | w_unmapped
               | (WE_I & w_sel_status)
               | (WE_I & w_sel_ctrl & DAT_I[START_BIT] & w_busy)
               | (WE_I & w_sel_div & w_busy);

  assign w_wr    = w_req & ~w_err & WE_I;
  assign w_start = w_wr & w_sel_ctrl & DAT_I[START_BIT];

  serializer_piso #(
    .DW (DW)
  ) u_piso (
    .i_clk        (CLK_I),
    .i_rst_n      (RST_I),
    .i_load       (w_start),
    .i_word       (r_data),
    .i_div        (r_div),
    .o_data       (data_o),
    .o_busy       (w_busy),
    .o_done_pulse (w_done_pulse)
  );

  // STATUS reflects the state after the accepting edge, so a frame ending
  // on that same edge already reads as not busy and done.
  always_comb begin
    w_rdata = '0;
    if (w_sel_data) begin
      w_rdata = r_data;
    end else if (w_sel_div) begin
      w_rdata = DW'(r_div);
    end else if (w_sel_status) begin
      w_rdata[BUSY_BIT] = w_busy & ~w_done_pulse;
      w_rdata[DONE_BIT] = r_done | w_done_pulse;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      r_data <= '0;
      r_div  <= '0;
      r_done <= 1'b0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_dat  <= '0;
    end else begin
      r_ack <= w_req & ~w_err;
      r_err <= w_req & w_err;
      r_dat <= (w_req & ~w_err & ~WE_I) ? w_rdata : '0;
      if (w_wr & w_sel_data) begin
        r_data <= DAT_I;
      end
      if (w_wr & w_sel_div) begin
        r_div <= DAT_I[DIV_W-1:0];
      end
      // START is only accepted while idle and the done pulse only occurs
      // while busy, so the two never collide.
      if (w_start) begin
        r_done <= 1'b0;
      end else if (w_done_pulse) begin
        r_done <= 1'b1;
      end
    end
  end

  assign ACK_O = r_ack;
  assign ERR_O = r_err;
  assign DAT_O = r_dat;

endmodule

// File: tb/tb_wb_serializer_unit.sv
// Purpose: directed self-checking bench for wb_serializer_unit with a serial-bit scoreboard.
// Latency: checks terminations one cycle after acceptance and data_o every cycle.
// Backpressure: n/a (bench drives one Wishbone request at a time).
module tb_wb_serializer_unit;

  logic        CLK_I;
  logic        RST_I;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic [3:0]  ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic        ERR_O;
  logic        data_o;

  int checks   = 0;
  int failures = 0;

  // Expected serial stream, one entry per clock cycle of a frame.
  bit q_bits[$];
  bit mon_en = 1'b0;

  // Bench-side model of the writable registers.
  logic [31:0] m_data = '0;
  logic [15:0] m_div  = '0;

  wb_serializer_unit #(
    .DW (32),
    .AW (4)
  ) dut (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .CYC_I  (CYC_I),
    .STB_I  (STB_I),
    .WE_I   (WE_I),
    .ADR_I  (ADR_I),
    .DAT_I  (DAT_I),
    .DAT_O  (DAT_O),
    .ACK_O  (ACK_O),
    .ERR_O  (ERR_O),
    .data_o (data_o)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Queue the serial image of the model's DATA at the model's DIV.
  task automatic push_frame();
    for (int b = 31; b >= 0; b--) begin
      for (int r = 0; r <= int'(m_div); r++) begin
        q_bits.push_back(m_data[b]);
      end
    end
  endtask

  // data_o is compared every cycle on the falling edge: a queued bit while
  // a frame is expected, otherwise the idle level 0.
  always @(negedge CLK_I) begin : mon
    bit e;
    if (mon_en) begin
      e = 1'b0;
      if (q_bits.size() != 0) e = q_bits.pop_front();
      chk("data_o", 32'(data_o), 32'(e));
    end
  end

  // One Wishbone access. The request is dropped right after acceptance;
  // termination must appear in the next cycle regardless, for one cycle only.
  task automatic bus(input bit we, input logic [3:0] adr, input logic [31:0] dat,
                     input bit exp_err, input logic [31:0] exp_rd, input string tag);
    @(posedge CLK_I);
    #2;
    CYC_I = 1'b1;
    STB_I = 1'b1;
    WE_I  = we;
    ADR_I = adr;
    DAT_I = dat;
    @(posedge CLK_I);
    #1;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    if (we && !exp_err) begin
      if (adr == 4'h0 && dat[0]) push_frame();
      if (adr == 4'h4) m_data = dat;
      if (adr == 4'h8) m_div = dat[15:0];
    end
    chk({tag, "_ack"}, 32'(ACK_O), 32'(!exp_err));
    chk({tag, "_err"}, 32'(ERR_O), 32'(exp_err));
    if (!we) chk({tag, "_rdata"}, DAT_O, exp_err ? 32'h0 : exp_rd);
    @(posedge CLK_I);
    #1;
    chk({tag, "_term_drop"}, {30'h0, ACK_O, ERR_O}, 32'h0);
    chk({tag, "_dat_idle"}, DAT_O, 32'h0);
  endtask

  task automatic wait_frame_end(input string tag);
    for (int i = 0; i < 4000; i++) begin
      if (q_bits.size() == 0) break;
      @(posedge CLK_I);
    end
    chk({tag, "_drain"}, 32'(q_bits.size()), 32'h0);
  endtask

  initial begin
    RST_I = 1'b0;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    ADR_I = '0;
    DAT_I = '0;

    // Reset for three cycles: all outputs low, STATUS empty.
    repeat (3) @(posedge CLK_I);
    #1;
    chk("rst_ack", 32'(ACK_O), 32'h0);
    chk("rst_err", 32'(ERR_O), 32'h0);
    chk("rst_dat", DAT_O, 32'h0);
    chk("rst_data_o", 32'(data_o), 32'h0);
    mon_en = 1'b1;
    RST_I  = 1'b1;
    bus(1'b0, 4'hC, 32'h0, 1'b0, 32'h0, "rst_status");
    bus(1'b0, 4'h4, 32'h0, 1'b0, 32'h0, "rst_data_reg");

    // Frame at one bit per cycle.
    bus(1'b1, 4'h4, 32'hA5A5_0F0F, 1'b0, 32'h0, "f1_wr_data");
    bus(1'b1, 4'h8, 32'h0, 1'b0, 32'h0, "f1_wr_div");
    bus(1'b1, 4'h0, 32'h1, 1'b0, 32'h0, "f1_start");
    wait_frame_end("f1");
    bus(1'b0, 4'hC, 32'h0, 1'b0, 32'h2, "f1_status_done");
    bus(1'b0, 4'h4, 32'h0, 1'b0, 32'hA5A5_0F0F, "f1_rd_data");

    // DIV=3 frame with refused accesses in mid-flight.
    bus(1'b1, 4'h8, 32'h3, 1'b0, 32'h0, "f2_wr_div");
    bus(1'b1, 4'h4, 32'h8000_0001, 1'b0, 32'h0, "f2_wr_data");
    bus(1'b1, 4'h0, 32'h1, 1'b0, 32'h0, "f2_start");
    bus(1'b0, 4'hC, 32'h0, 1'b0, 32'h1, "f2_status_busy");
    bus(1'b1, 4'h0, 32'h1, 1'b1, 32'h0, "f2_start_busy");
    bus(1'b1, 4'h8, 32'h7, 1'b1, 32'h0, "f2_div_busy");
    bus(1'b1, 4'hC, 32'h3, 1'b1, 32'h0, "f2_wr_status");
    bus(1'b1, 4'h0, 32'h0, 1'b0, 32'h0, "f2_ctrl_noop_busy");
    bus(1'b1, 4'h4, 32'h0F0F_1234, 1'b0, 32'h0, "f2_wr_data_busy");
    bus(1'b0, 4'hC, 32'h0, 1'b0, 32'h1, "f2_status_busy2");
    wait_frame_end("f2");
    bus(1'b0, 4'hC, 32'h0, 1'b0, 32'h2, "f2_status_done");
    bus(1'b0, 4'h8, 32'h0, 1'b0, 32'h3, "f2_rd_div");

    // Next frame carries the word written while busy.
    bus(1'b1, 4'h8, 32'h1, 1'b0, 32'h0, "f3_wr_div");
    bus(1'b1, 4'h0, 32'h1, 1'b0, 32'h0, "f3_start");
    wait_frame_end("f3");
    bus(1'b0, 4'hC, 32'h0, 1'b0, 32'h2, "f3_status_done");

    // Address decode and DIV width.
    bus(1'b0, 4'h2, 32'h0, 1'b1, 32'h0, "unaligned_rd");
    bus(1'b1, 4'h6, 32'hFFFF_FFFF, 1'b1, 32'h0, "unaligned_wr");
    bus(1'b1, 4'h8, 32'h1234_FFFF, 1'b0, 32'h0, "div_wr_wide");
    bus(1'b0, 4'h8, 32'h0, 1'b0, 32'h0000_FFFF, "div_rd_wide");
    bus(1'b0, 4'h0, 32'h0, 1'b0, 32'h0, "ctrl_rd");
    bus(1'b1, 4'h0, 32'h0, 1'b0, 32'h0, "ctrl_noop");
    bus(1'b0, 4'hC, 32'h0, 1'b0, 32'h2, "noop_keeps_done");

    // Reset in mid-frame aborts without DONE.
    bus(1'b1, 4'h8, 32'h0, 1'b0, 32'h0, "f4_wr_div");
    bus(1'b1, 4'h4, 32'hFFFF_FFFF, 1'b0, 32'h0, "f4_wr_data");
    bus(1'b1, 4'h0, 32'h1, 1'b0, 32'h0, "f4_start");
    repeat (4) @(posedge CLK_I);
    #2;
    RST_I = 1'b0;
    @(posedge CLK_I);
    #1;
    q_bits.delete();
    m_data = '0;
    m_div  = '0;
    chk("midrst_data_o", 32'(data_o), 32'h0);
    chk("midrst_term", {30'h0, ACK_O, ERR_O}, 32'h0);
    RST_I = 1'b1;
    bus(1'b0, 4'hC, 32'h0, 1'b0, 32'h0, "midrst_status");
    bus(1'b0, 4'h4, 32'h0, 1'b0, 32'h0, "midrst_data_reg");
    bus(1'b0, 4'h8, 32'h0, 1'b0, 32'h0, "midrst_div_reg");
    repeat (3) @(posedge CLK_I);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_serializer_unit.md
# wb_serializer_unit

Wishbone B4 classic slave that accepts a 32-bit word over the bus and shifts it out MSB-first on a single-bit line at a programmable bit rate. It sits between a Wishbone master, such as a CPU or a bus functional model, and a serial sink. It gives software a register interface for data, start, divider and status. It runs on one clock shared by the bus and the serializer.

## Interface
Parameters:
- DW, 32: data bus width and frame length in bits.
- AW, 4: byte address width. Registers are word-aligned at 0x0, 0x4, 0x8 and 0xC.

Ports:
- CLK_I  in  1  the single clock. It clocks both the bus logic and the serializer.
- RST_I  in  1  synchronous, active-low reset. It is sampled on the CLK_I rising edge.
- CYC_I  in  1  Wishbone cycle.
- STB_I  in  1  Wishbone strobe.
- WE_I  in  1  write enable. 1 means write.
- ADR_I  in  AW  byte address.
- DAT_I  in  DW  write data.
- DAT_O  out  DW  read data. It is valid while ACK_O is high and 0 otherwise.
- ACK_O  out  1  normal termination.
- ERR_O  out  1  error termination.
- data_o  out  1  serial output.

## Operation
Register map:
- 0x0 CTRL (write-only; reads return 0)
  - bit0 START: writing 1 launches a frame. The bit self-clears.
- 0x4 DATA (read/write): the 32-bit word to send.
  - Writing while busy is legal.
  - The new value only affects the next frame.
- 0x8 DIV (read/write): bits[15:0] hold the number of extra cycles per bit, so each bit lasts DIV+1 cycles. Bits[31:16] are read as 0.
- 0xC STATUS (read-only)
  - bit0 BUSY.
  - bit1 DONE, sticky. It sets when a frame completes and clears on the next accepted START.

Error (ERR_O instead of ACK_O; the access has no side effect) for any of these:
- ADR_I[1:0] is not 0.
- Any write to STATUS.
- A START write while BUSY=1.
- A DIV write while BUSY=1.

A CTRL write with START=0 is acked as a no-op.

Serializer states:
- IDLE
  - data_o=0 and BUSY=0.
  - On an accepted START: load the shift register from DATA, load bit count 31 and divider count DIV, then go to SHIFT.
- SHIFT
  - data_o = shreg[DW-1].
  - Each cycle the divider count decrements. When it is 0 and the bit count is >0, shift left, decrement the bit count and reload the divider.
  - When the divider is 0 and the bit count is 0, return to IDLE, set DONE and drive data_o=0.

Reset, while RST_I=0 at an edge:
- Outputs: ACK_O, ERR_O, DAT_O and data_o are 0.
- Registers: DATA, DIV, BUSY, DONE and the shift state are 0.
- State returns to IDLE.
- A reset in mid-frame aborts the frame immediately, and DONE is not set.

## Timing
Bus handshake:
- A request is accepted at a rising edge when CYC_I & STB_I & !ACK_O & !ERR_O.
- Exactly one of ACK_O or ERR_O rises in the following cycle, lasts exactly one cycle, and then drops. This gives one wait state, and back-to-back requests complete every 2 cycles.
- If CYC_I or STB_I falls before termination, the request is still completed.

Write effects:
- Register writes take effect at the accepting edge.
- START accepted at edge k: BUSY=1 and data_o=DATA[31] are visible after edge k, in the same cycle as the ACK_O.

Frame timing:
- Bit i (counting from the MSB) is held for exactly DIV+1 cycles.
- A frame lasts 32·(DIV+1) cycles, after which BUSY=0 and DONE=1 on the same edge that returns data_o to 0.

Read timing:
- A STATUS read returns state as of the accepting edge.
- If a frame completes at that same edge, the read reports BUSY=0 and DONE=1.

## Structure
- Package wb_serializer_pkg holds:
  - Address constants: ADDR_CTRL, ADDR_DATA, ADDR_DIV, ADDR_STATUS.
  - Bit positions: START_BIT, BUSY_BIT, DONE_BIT.
  - The serializer state enum, IDLE and SHIFT.
- One sub-module, serializer_piso, holds the shift register, the bit and divider counters, and the state machine.
  - Inputs: load, word and div.
  - Outputs: data_o, busy and done_pulse.
- The top level holds the Wishbone decode, the registers and the ACK/ERR generation.

## Test plan
- Reset with RST_I=0 for 3 cycles: all outputs are 0 and STATUS reads 0x0.
- Write DATA=0xA5A5_0F0F, DIV=0, then START: data_o emits 1010_0101_1010_0101_0000_1111_0000_1111 at one bit per cycle. BUSY=1 for 32 cycles, after which STATUS reads 0x2.
- DIV=3 and DATA=0x8000_0001: data_o is 1 for 4 cycles, 0 for 120 cycles, then 1 for 4 cycles. The frame totals 128 cycles.
- During a frame, START, a DIV write, and a write to 0xC each return ERR_O, and the frame continues unaltered. A DATA write returns ACK_O, and the next frame sends the new word.
- Access to address 0x2 (unaligned) or 0x6 returns ERR_O. Read back DIV=0x1234_FFFF written: it reads 0x0000_FFFF with ACK_O one cycle after the request.
- Deassert RST_I in mid-frame for 1 cycle: data_o=0, BUSY=0 and DONE=0 at the next cycle.
